// File: rtl/mii_frame_generator_if.sv
// mii_frame_generator_if: frame request/config inputs and MII transmit outputs of the generator
interface mii_frame_generator_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 8
);
   logic                  i_start;
   logic [7:0]            i_payload_len;
   logic [7:0]            i_ipg_len;
   logic [7:0]            i_seed;
   logic [DATA_WIDTH-1:0] o_tx_data;
   logic [CTRL_WIDTH-1:0] o_tx_ctrl;
   logic                  o_ready;
   logic [15:0]           o_frame_count;
   modport master (
      output i_start, i_payload_len, i_ipg_len, i_seed,
      input  o_tx_data, o_tx_ctrl, o_ready, o_frame_count
   );
   modport slave (
      input  i_start, i_payload_len, i_ipg_len, i_seed,
      output o_tx_data, o_tx_ctrl, o_ready, o_frame_count
   );
endinterface

// File: rtl/mii_frame_generator.sv
// mii_frame_generator: emits START/DATA/TERM framed MII words with an incrementing payload and an enforced inter-packet gap
module mii_frame_generator #(
   parameter int         DATA_WIDTH = 64,
   parameter int         CTRL_WIDTH = 8,
   parameter logic [7:0] IDLE_CODE  = 8'h07,
   parameter logic [7:0] START_CODE = 8'hFB,
   parameter logic [7:0] TERM_CODE  = 8'hFD
) (
   input logic                  clk,
   input logic                  i_rst_n,
   mii_frame_generator_if.slave bus
);
   localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{IDLE_CODE}};
   typedef enum logic [2:0] {IDLE, START, DATA, TERM, GAP} state_t;
   state_t                state;
   logic [7:0]            nb;
   logic [7:0]            rem;
   logic [7:0]            ipg;
   logic [8:0]            acc;
   logic [8:0]            a_term;
   logic [7:0]            len_eff;
   logic [DATA_WIDTH-1:0] start_word;
   logic [DATA_WIDTH-1:0] data_word;
   logic [DATA_WIDTH-1:0] term_word;
   logic [CTRL_WIDTH-1:0] term_ctrl;
   // candidate next words: START from the live request, DATA/TERM from the next payload byte nb and remaining count rem
   always_comb begin
      len_eff = bus.i_payload_len < 8'd7 ? 8'd7 : bus.i_payload_len;
      a_term  = 9'd7 - {1'b0, rem};
      for (int j = 0; j < CTRL_WIDTH; j++) begin
         start_word[8*j +: 8] = j == 0 ? START_CODE : bus.i_seed + 8'(j - 1);
         data_word[8*j +: 8]  = nb + 8'(j);
         term_word[8*j +: 8]  = j < int'(rem) ? nb + 8'(j) : (j == int'(rem) ? TERM_CODE : IDLE_CODE);
         term_ctrl[j]         = j >= int'(rem);
      end
   end
   // frame sequencer: each transition loads the word belonging to the state being entered
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state             <= IDLE;
         bus.o_tx_data     <= IDLE_WORD;
         bus.o_tx_ctrl     <= '1;
         bus.o_ready       <= 1'b1;
         bus.o_frame_count <= '0;
         nb                <= '0;
         rem               <= '0;
         ipg               <= '0;
         acc               <= '0;
      end else
         case (state)
            IDLE:
               if (bus.i_start) begin
                  state         <= START;
                  bus.o_tx_data <= start_word;
                  bus.o_tx_ctrl <= CTRL_WIDTH'(1);
                  bus.o_ready   <= 1'b0;
                  nb            <= bus.i_seed + 8'd7;
                  rem           <= len_eff - 8'd7;
                  ipg           <= bus.i_ipg_len;
               end
            START, DATA:
               if (rem >= 8'd8) begin
                  state         <= DATA;
                  bus.o_tx_data <= data_word;
                  bus.o_tx_ctrl <= '0;
                  nb            <= nb + 8'd8;
                  rem           <= rem - 8'd8;
               end else begin
                  state         <= TERM;
                  bus.o_tx_data <= term_word;
                  bus.o_tx_ctrl <= term_ctrl;
               end
            TERM: begin
               bus.o_frame_count <= bus.o_frame_count + 16'd1;
               bus.o_tx_data     <= IDLE_WORD;
               bus.o_tx_ctrl     <= '1;
               if (a_term >= {1'b0, ipg}) begin
                  state       <= IDLE;
                  bus.o_ready <= 1'b1;
               end else begin
                  state <= GAP;
                  acc   <= a_term + 9'd8;
               end
            end
            GAP:
               if (acc >= {1'b0, ipg}) begin
                  state       <= IDLE;
                  bus.o_ready <= 1'b1;
               end else
                  acc <= acc + 9'd8;
            default: begin
               state         <= IDLE;
               bus.o_tx_data <= IDLE_WORD;
               bus.o_tx_ctrl <= '1;
               bus.o_ready   <= 1'b1;
            end
         endcase
endmodule

// File: tb/tb_mii_frame_generator.sv
// tb_mii_frame_generator: random and directed frames checked against a byte-stream model of the MII framing
module tb_mii_frame_generator;
   localparam logic [63:0] IDLE_W = 64'h0707070707070707;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_count = '0;
   logic [63:0] ew_d[$];
   logic [7:0]  ew_c[$];
   int          term_idx;

   mii_frame_generator_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

   mii_frame_generator dut (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Lay the frame out as a byte stream (FB, payload, FD, idle fill to a word boundary,
   // whole idle words until the gap is met) and cut it into 8-byte words.
   function automatic void build(int len, int seed, int ipg);
      logic [7:0] b[$];
      logic       c[$];
      int         l;
      int         idle;
      l = len < 7 ? 7 : len;
      b.push_back(8'hFB);
      c.push_back(1'b1);
      for (int n = 0; n < l; n++) begin
         b.push_back(8'((seed + n) % 256));
         c.push_back(1'b0);
      end
      term_idx = b.size() / 8;
      b.push_back(8'hFD);
      c.push_back(1'b1);
      idle = 0;
      while (b.size() % 8 != 0) begin
         b.push_back(8'h07);
         c.push_back(1'b1);
         idle++;
      end
      while (idle < ipg) begin
         for (int j = 0; j < 8; j++) begin
            b.push_back(8'h07);
            c.push_back(1'b1);
         end
         idle += 8;
      end
      ew_d.delete();
      ew_c.delete();
      for (int w = 0; w < b.size() / 8; w++) begin
         logic [63:0] d;
         logic [7:0]  cc;
         for (int j = 0; j < 8; j++) begin
            d[8*j +: 8] = b[8*w + j];
            cc[j]       = c[8*w + j];
         end
         ew_d.push_back(d);
         ew_c.push_back(cc);
      end
   endfunction

   task automatic chk_idle(string tag);
      chk({tag, "_data"}, bus.o_tx_data, IDLE_W);
      chk({tag, "_ctrl"}, 64'(bus.o_tx_ctrl), 64'hFF);
      chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
      chk({tag, "_count"}, 64'(bus.o_frame_count), 64'(exp_count));
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge showing the next IDLE word.
   task automatic run_frame(int len, int seed, int ipg, bit perturb, bit hold, int rst_at);
      build(len, seed, ipg);
      chk_idle("pre");
      bus.i_start       = 1'b1;
      bus.i_payload_len = 8'(len);
      bus.i_seed        = 8'(seed);
      bus.i_ipg_len     = 8'(ipg);
      for (int i = 0; i < ew_d.size(); i++) begin
         @(negedge clk);
         if (!hold) bus.i_start = 1'b0;
         chk($sformatf("w%0d_data", i), bus.o_tx_data, ew_d[i]);
         chk($sformatf("w%0d_ctrl", i), 64'(bus.o_tx_ctrl), 64'(ew_c[i]));
         chk($sformatf("w%0d_ready", i), 64'(bus.o_ready), 64'd0);
         chk($sformatf("w%0d_count", i), 64'(bus.o_frame_count),
             64'(i <= term_idx ? exp_count : exp_count + 16'd1));
         if (i == rst_at) begin
            rst_n       = 1'b0;
            bus.i_start = 1'b0;
            exp_count   = '0;
            #1;
            chk_idle("rst_async");
            @(negedge clk);
            chk_idle("rst_hold");
            rst_n = 1'b1;
            return;
         end
         if (perturb) begin
            if (!hold) bus.i_start = 1'($urandom);
            bus.i_payload_len = 8'($urandom);
            bus.i_seed        = 8'($urandom);
            bus.i_ipg_len     = 8'($urandom);
         end
      end
      exp_count++;
      @(negedge clk);
   endtask

   initial begin
      bus.i_start       = 1'b0;
      bus.i_payload_len = '0;
      bus.i_ipg_len     = '0;
      bus.i_seed        = '0;
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(46, 8'h00, 12, 1'b0, 1'b0, -1);
      run_frame(64, 8'hF0, 12, 1'b0, 1'b0, -1);
      run_frame(3, 8'h55, 0, 1'b0, 1'b0, -1);
      run_frame(100, 8'h10, 20, 1'b1, 1'b0, -1);
      run_frame(0, 8'hA0, 0, 1'b0, 1'b1, -1);
      run_frame(9, 8'h33, 5, 1'b1, 1'b1, -1);
      run_frame(255, 8'hFF, 255, 1'b1, 1'b0, -1);
      run_frame(46, 8'h00, 12, 1'b0, 1'b0, 1);
      run_frame(46, 8'h00, 12, 1'b0, 1'b0, -1);
      for (int r = 0; r < 25; r++)
         run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), -1);
      bus.i_start = 1'b0;
      chk_idle("end");
      @(negedge clk);
      chk_idle("end_hold");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
